// File: rtl/axi_pkg.sv
// Shared AXI constants and the write-splitter state type.
// Used by the AXI4-to-AXI3 write bridge and its bench.
package axi_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_RESP = 3'd4
  } wr_split_state_t;

endpackage

// File: rtl/axi4_to_axi3_wr_splitter.sv
// Splits one AXI4 write burst at a time into AXI3 sub-bursts of at most
// MAX_BEATS beats and folds the sub-burst responses into one AXI4 B response.
module axi4_to_axi3_wr_splitter
  import axi_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDR_BYTES    = 4,
  parameter int NUM_ID_BITS_P = 4,
  parameter int MAX_BEATS     = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [ADDR_BYTES*8-1:0]    s_awaddr,
  input  logic [NUM_ID_BITS_P-1:0]   s_awid,
  input  logic [7:0]                 s_awlen,
  input  logic [2:0]                 s_awsize,
  input  logic [1:0]                 s_awburst,
  input  logic                       s_awlock,
  input  logic [3:0]                 s_awcache,
  input  logic [2:0]                 s_awprot,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  input  logic [DATA_BYTES*8-1:0]    s_wdata,
  input  logic [DATA_BYTES-1:0]      s_wstrb,
  input  logic                       s_wlast,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  output logic [1:0]                 s_bresp,
  output logic [NUM_ID_BITS_P-1:0]   s_bid,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [ADDR_BYTES*8-1:0]    m_awaddr,
  output logic [NUM_ID_BITS_P-1:0]   m_awid,
  output logic [3:0]                 m_awlen,
  output logic [2:0]                 m_awsize,
  output logic [1:0]                 m_awburst,
  output logic [1:0]                 m_awlock,
  output logic [3:0]                 m_awcache,
  output logic [2:0]                 m_awprot,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [DATA_BYTES*8-1:0]    m_wdata,
  output logic [DATA_BYTES-1:0]      m_wstrb,
  output logic                       m_wlast,
  output logic [NUM_ID_BITS_P-1:0]   m_wid,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp,
  input  logic [NUM_ID_BITS_P-1:0]   m_bid,
  output logic [2:0]                 dbg_state_o
);

  localparam int AW_W = ADDR_BYTES * 8;

  // Handshakes: a transfer happens on any rising aclk where valid && ready;
  // valids never wait on ready, and payload holds while valid && !ready.

  wr_split_state_t            state_q, state_d;
  logic [AW_W-1:0]            addr_q, addr_d;
  logic [NUM_ID_BITS_P-1:0]   id_q, id_d;
  logic [2:0]                 size_q, size_d;
  logic [1:0]                 burst_q, burst_d;
  logic                       lock_q, lock_d;
  logic [3:0]                 cache_q, cache_d;
  logic [2:0]                 prot_q, prot_d;
  logic [8:0]                 rem_q, rem_d;
  logic [8:0]                 n_sub_q, n_sub_d;
  logic [8:0]                 b_cnt_q, b_cnt_d;
  logic [1:0]                 worst_q, worst_d;
  logic [4:0]                 beat_q, beat_d;
  logic [4:0]                 sub_q, sub_d;
  logic                       rst_done_q;

  logic [8:0]                 rem_new;
  logic [4:0]                 wrap_beats;
  logic [AW_W-1:0]            step;
  logic                       unused_inputs;

  function automatic logic [4:0] sub_beats(input logic [8:0] r);
    return (r > 9'(MAX_BEATS)) ? 5'(MAX_BEATS) : r[4:0];
  endfunction

  assign rem_new    = 9'(s_awlen) + 9'd1;
  assign wrap_beats = {1'b0, s_awlen[3:0]} + 5'd1;
  assign step       = AW_W'(MAX_BEATS) << size_q;
  assign unused_inputs = ^{s_wlast, m_bid};

  // Responses are accepted in AW/W/B so early sub-burst B's never block the fabric.
  assign m_bready = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    size_d    = size_q;
    burst_d   = burst_q;
    lock_d    = lock_q;
    cache_d   = cache_q;
    prot_d    = prot_q;
    rem_d     = rem_q;
    n_sub_d   = n_sub_q;
    b_cnt_d   = b_cnt_q;
    worst_d   = worst_q;
    beat_d    = beat_q;
    sub_d     = sub_q;
    s_awready = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;

    if (m_bvalid && m_bready) begin
      b_cnt_d = b_cnt_q + 9'd1;
      if (m_bresp > worst_q) worst_d = m_bresp;
    end

    case (state_q)
      ST_IDLE: begin
        s_awready = rst_done_q;
        if (s_awvalid && rst_done_q) begin
          addr_d  = s_awaddr;
          id_d    = s_awid;
          size_d  = s_awsize;
          burst_d = s_awburst;
          lock_d  = s_awlock;
          cache_d = s_awcache;
          prot_d  = s_awprot;
          b_cnt_d = '0;
          worst_d = '0;
          beat_d  = '0;
          if (s_awburst == BURST_WRAP) begin
            rem_d   = 9'(wrap_beats);
            n_sub_d = 9'd1;
            sub_d   = wrap_beats;
          end else begin
            rem_d   = rem_new;
            n_sub_d = (rem_new + 9'(MAX_BEATS - 1)) / 9'(MAX_BEATS);
            sub_d   = sub_beats(rem_new);
          end
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_d = ST_W;
      end
      ST_W: begin
        m_wvalid = s_wvalid;
        s_wready = m_wready;
        if (s_wvalid && m_wready) begin
          if (m_wlast) begin
            beat_d = '0;
            rem_d  = rem_q - 9'(sub_q);
            if (rem_d != 9'd0) begin
              sub_d = sub_beats(rem_d);
              if (burst_q == BURST_INCR) addr_d = addr_q + step;
              state_d = ST_AW;
            end else begin
              state_d = ST_B;
            end
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      ST_B: begin
        if (b_cnt_d == n_sub_q) state_d = ST_RESP;
      end
      ST_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          b_cnt_d = '0;
          worst_d = '0;
          rem_d   = '0;
          n_sub_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      id_q       <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      lock_q     <= 1'b0;
      cache_q    <= '0;
      prot_q     <= '0;
      rem_q      <= '0;
      n_sub_q    <= '0;
      b_cnt_q    <= '0;
      worst_q    <= '0;
      beat_q     <= '0;
      sub_q      <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      lock_q     <= lock_d;
      cache_q    <= cache_d;
      prot_q     <= prot_d;
      rem_q      <= rem_d;
      n_sub_q    <= n_sub_d;
      b_cnt_q    <= b_cnt_d;
      worst_q    <= worst_d;
      beat_q     <= beat_d;
      sub_q      <= sub_d;
      rst_done_q <= 1'b1;
    end
  end

  assign m_awaddr    = addr_q;
  assign m_awid      = id_q;
  assign m_awlen     = 4'(sub_q - 5'd1);
  assign m_awsize    = size_q;
  assign m_awburst   = burst_q;
  assign m_awlock    = {1'b0, lock_q};
  assign m_awcache   = cache_q;
  assign m_awprot    = prot_q;
  assign m_wdata     = s_wdata;
  assign m_wstrb     = s_wstrb;
  assign m_wid       = id_q;
  assign m_wlast     = (state_q == ST_W) && (beat_q == sub_q - 5'd1);
  assign s_bresp     = worst_q;
  assign s_bid       = id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi4_to_axi3_wr_splitter.sv
// Bench for the AXI4-to-AXI3 write splitter: directed bursts, random bursts
// with random stalls, and a reset in the middle of a data phase.
`timescale 1ns/1ps
module tb_axi4_to_axi3_wr_splitter;
  import axi_pkg::*;

  localparam int DB  = 4;
  localparam int ABY = 4;
  localparam int IDW = 4;
  localparam int MB  = 16;
  localparam int AWD = ABY * 8;
  localparam int DW  = DB * 8;

  // clock / reset
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic           s_awvalid, s_awready;
  logic [AWD-1:0] s_awaddr;
  logic [IDW-1:0] s_awid;
  logic [7:0]     s_awlen;
  logic [2:0]     s_awsize;
  logic [1:0]     s_awburst;
  logic           s_awlock;
  logic [3:0]     s_awcache;
  logic [2:0]     s_awprot;
  logic           s_wvalid, s_wready;
  logic [DW-1:0]  s_wdata;
  logic [DB-1:0]  s_wstrb;
  logic           s_wlast;
  logic           s_bvalid, s_bready;
  logic [1:0]     s_bresp;
  logic [IDW-1:0] s_bid;
  logic           m_awvalid, m_awready;
  logic [AWD-1:0] m_awaddr;
  logic [IDW-1:0] m_awid;
  logic [3:0]     m_awlen;
  logic [2:0]     m_awsize;
  logic [1:0]     m_awburst;
  logic [1:0]     m_awlock;
  logic [3:0]     m_awcache;
  logic [2:0]     m_awprot;
  logic           m_wvalid, m_wready;
  logic [DW-1:0]  m_wdata;
  logic [DB-1:0]  m_wstrb;
  logic           m_wlast;
  logic [IDW-1:0] m_wid;
  logic           m_bvalid, m_bready;
  logic [1:0]     m_bresp;
  logic [IDW-1:0] m_bid;
  logic [2:0]     dbg_state;

  axi4_to_axi3_wr_splitter #(
    .DATA_BYTES(DB), .ADDR_BYTES(ABY), .NUM_ID_BITS_P(IDW), .MAX_BEATS(MB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock),
    .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wid(m_wid),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .dbg_state_o(dbg_state)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [AWD+3:0]  exp_aw_q[$];      // {addr, len}
  logic [DW+DB:0]  exp_w_q[$];       // {data, strb, last}
  logic [1:0]      forced_q[$];
  logic [AWD-1:0]  obs_addr_q[$];
  logic [3:0]      obs_len_q[$];
  int              obs_wlast;
  logic [1:0]      obs_bresp;
  logic [IDW-1:0]  obs_bid;
  logic [IDW-1:0]  cur_id;
  logic [2:0]      cur_size;
  logic [1:0]      cur_burst;
  logic            cur_lock;
  logic [3:0]      cur_cache;
  logic [2:0]      cur_prot;
  logic [1:0]      exp_worst;
  int              b_owed = 0;
  bit              sb_done = 0;
  bit              mb_hs = 0;
  int              last_mb_cyc = 0;
  bit              aw_next_chk = 0;
  logic            p_awv, p_awr, p_sbv, p_sbr;
  logic [AWD-1:0]  p_awaddr;
  logic [3:0]      p_awlen;
  logic [1:0]      p_bresp;
  logic [IDW-1:0]  p_bid;
  logic [AWD+3:0]  e_aw;
  logic [DW+DB:0]  e_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event required=no event", name);
  endtask

  // slave-side drivers
  initial begin
    m_awready = 1'b0; m_wready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      m_awready = ($urandom_range(0, 2) != 0);
      m_wready  = ($urandom_range(0, 3) != 0);
      s_bready  = ($urandom_range(0, 1) != 0);
    end
  end

  initial begin
    m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = '0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn) m_bvalid = 1'b0;
      else if (!m_bvalid || mb_hs) begin
        m_bvalid = 1'b0;
        if (b_owed > 0 && $urandom_range(0, 3) != 0) begin
          b_owed--;
          m_bvalid = 1'b1;
          if (forced_q.size() > 0) m_bresp = forced_q.pop_front();
          else m_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : BRESP_OKAY;
          m_bid = IDW'($urandom);
          if (m_bresp > exp_worst) exp_worst = m_bresp;
        end
      end
    end
  end

  // monitor / compare process
  always @(negedge aclk) begin
    if (aresetn) begin
      if (p_awv && !p_awr)
        check("m_aw_hold", {m_awvalid, m_awaddr, m_awlen}, {1'b1, p_awaddr, p_awlen});
      if (p_sbv && !p_sbr)
        check("s_b_hold", {s_bvalid, s_bresp, s_bid}, {1'b1, p_bresp, p_bid});
      if (aw_next_chk) begin
        check("m_awvalid_latency", m_awvalid, 1'b1);
        aw_next_chk = 0;
      end
      if (s_awvalid && s_awready) aw_next_chk = 1;
      if (m_awvalid && m_awready) begin
        if (exp_aw_q.size() == 0) fail("m_aw_unexpected");
        else begin
          e_aw = exp_aw_q.pop_front();
          check("m_awaddr", m_awaddr, e_aw[AWD+3:4]);
          check("m_awlen", m_awlen, e_aw[3:0]);
          check("m_aw_attr", {m_awid, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot},
                {cur_id, cur_size, cur_burst, 1'b0, cur_lock, cur_cache, cur_prot});
        end
        obs_addr_q.push_back(m_awaddr);
        obs_len_q.push_back(m_awlen);
      end
      if (m_wvalid && m_wready) begin
        if (exp_w_q.size() == 0) fail("m_w_unexpected");
        else begin
          e_w = exp_w_q.pop_front();
          check("m_w_beat", {m_wdata, m_wstrb, m_wlast}, e_w);
          check("m_wid", m_wid, cur_id);
        end
        if (m_wlast) begin
          b_owed++;
          obs_wlast++;
          if (exp_aw_q.size() > 0) aw_next_chk = 1;
        end
      end
      mb_hs = m_bvalid && m_bready;
      if (mb_hs) last_mb_cyc = cyc;
      if (s_bvalid && !p_sbv) check("s_bvalid_latency", 64'(cyc), 64'(last_mb_cyc + 1));
      if (s_bvalid && s_bready) begin
        check("s_bresp", s_bresp, exp_worst);
        check("s_bid", s_bid, cur_id);
        obs_bresp = s_bresp;
        obs_bid = s_bid;
        sb_done = 1;
      end
      p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr; p_awlen = m_awlen;
      p_sbv = s_bvalid;  p_sbr = s_bready;  p_bresp = s_bresp;   p_bid = s_bid;
    end else begin
      p_awv = 0; p_awr = 0; p_sbv = 0; p_sbr = 0;
      mb_hs = 0; aw_next_chk = 0;
    end
  end

  // master driver; abort_after >= 0 asserts reset after that many data beats
  task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input int abort_after);
    int total, left, n, t;
    logic [31:0] a;
    logic [DW-1:0] d[$];
    logic [DB-1:0] s[$];
    logic lastb;
    cur_id = id; cur_size = size; cur_burst = burst;
    cur_lock = 1'($urandom); cur_cache = 4'($urandom); cur_prot = 3'($urandom);
    exp_worst = BRESP_OKAY; sb_done = 0;
    obs_addr_q.delete(); obs_len_q.delete(); obs_wlast = 0;
    total = (burst == BURST_WRAP) ? int'(len[3:0]) + 1 : int'(len) + 1;
    if (burst == BURST_WRAP) exp_aw_q.push_back({addr, len[3:0]});
    else begin
      left = total; a = addr;
      while (left > 0) begin
        n = (left > MB) ? MB : left;
        exp_aw_q.push_back({a, 4'(n - 1)});
        if (burst == BURST_INCR) a = a + (32'(MB) << size);
        left -= n;
      end
    end
    for (int i = 0; i < total; i++) begin
      d.push_back($urandom);
      s.push_back(DB'($urandom));
      lastb = (burst == BURST_WRAP) ? (i == total - 1) : (((i + 1) % MB == 0) || (i == total - 1));
      exp_w_q.push_back({d[i], s[i], lastb});
    end

    @(posedge aclk); #1;
    s_awvalid = 1'b1; s_awaddr = addr; s_awid = id; s_awlen = len; s_awsize = size;
    s_awburst = burst; s_awlock = cur_lock; s_awcache = cur_cache; s_awprot = cur_prot;
    for (t = 0; t < 1000; t++) begin
      @(negedge aclk);
      if (s_awready) break;
      @(posedge aclk); #1;
    end
    if (t == 1000) fail("s_aw_timeout");
    @(posedge aclk); #1;
    s_awvalid = 1'b0;

    for (int i = 0; i < total; i++) begin
      s_wvalid = 1'b1; s_wdata = d[i]; s_wstrb = s[i]; s_wlast = 1'($urandom);
      if (i == abort_after) begin
        #1;
        aresetn = 1'b0;
        #1;
        check("reset_outputs", {m_awvalid, m_wvalid, s_bvalid, s_wready, m_bready, s_awready, m_wlast}, 7'b0);
        s_wvalid = 1'b0;
        return;
      end
      for (t = 0; t < 1000; t++) begin
        @(negedge aclk);
        if (s_wready) break;
        @(posedge aclk); #1;
      end
      if (t == 1000) fail("s_w_timeout");
      @(posedge aclk); #1;
      s_wvalid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
    end

    for (t = 0; t < 5000; t++) begin
      @(negedge aclk);
      if (sb_done) break;
    end
    if (t == 5000) fail("s_b_timeout");
    check("model_drained", {32'(exp_aw_q.size()), 32'(exp_w_q.size())}, 64'd0);
  endtask

  initial begin : stim
    logic [1:0] burst;
    logic [7:0] len;
    int bt;
    s_awvalid = 0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_awlock = 0; s_awcache = '0; s_awprot = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
    s_wlast = 0; s_bready = 0;

    #12;
    check("reset_ctrl", {s_awready, s_wready, m_awvalid, m_wvalid, m_bready, s_bvalid, m_wlast}, 7'b0);
    check("reset_payload", {s_bresp, dbg_state, m_awaddr}, '0);
    #21 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("idle_awready", {s_awready, dbg_state}, {1'b1, ST_IDLE});

    forced_q = '{BRESP_OKAY};
    run_txn(32'h100, 8'd0, 3'd2, BURST_INCR, 4'd3, -1);
    check("t1_aw_count", 64'(obs_addr_q.size()), 64'd1);
    check("t1_aw", {obs_addr_q[0], obs_len_q[0]}, {32'h100, 4'd0});
    check("t1_wlast_bresp", {32'(obs_wlast), 30'd0, obs_bresp}, {32'd1, 32'd0});

    run_txn(32'h1000, 8'd255, 3'd2, BURST_INCR, 4'd5, -1);
    check("t2_aw_count", {32'(obs_addr_q.size()), 32'(obs_wlast)}, {32'd16, 32'd16});
    check("t2_addr1", {obs_addr_q[1], obs_len_q[1]}, {32'h1040, 4'd15});
    check("t2_addr15", {obs_addr_q[15], obs_len_q[15]}, {32'h13C0, 4'd15});

    run_txn(32'h2000, 8'd20, 3'd2, BURST_INCR, 4'd1, -1);
    check("t3_aw_count", 64'(obs_addr_q.size()), 64'd2);
    check("t3_aw", {obs_addr_q[0], obs_len_q[0], obs_addr_q[1], obs_len_q[1]},
          {32'h2000, 4'd15, 32'h2040, 4'd4});

    run_txn(32'h3000, 8'd31, 3'd2, BURST_FIXED, 4'd2, -1);
    check("t4_aw", {32'(obs_addr_q.size()), obs_addr_q[0], obs_len_q[0], obs_addr_q[1], obs_len_q[1]},
          {32'd2, 32'h3000, 4'd15, 32'h3000, 4'd15});

    run_txn(32'h4010, 8'd7, 3'd2, BURST_WRAP, 4'd7, -1);
    check("t5_wrap", {32'(obs_addr_q.size()), obs_len_q[0], 32'(obs_wlast)}, {32'd1, 4'd7, 32'd1});

    forced_q = '{BRESP_OKAY, BRESP_SLVERR, BRESP_OKAY};
    run_txn(32'h5000, 8'd47, 3'd2, BURST_INCR, 4'd9, -1);
    check("t6_merge", {obs_bresp, obs_bid}, {2'd2, 4'd9});

    for (int k = 0; k < 25; k++) begin
      bt = $urandom_range(0, 5);
      burst = (bt == 0) ? BURST_FIXED : (bt == 5) ? BURST_WRAP : BURST_INCR;
      if (burst == BURST_WRAP) len = 8'((2 << $urandom_range(0, 3)) - 1);
      else len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      run_txn({16'($urandom), 16'h0}, len, 3'($urandom_range(0, 2)), burst, 4'($urandom), -1);
    end

    run_txn(32'h6000, 8'd31, 3'd2, BURST_INCR, 4'd4, 5);
    exp_aw_q.delete(); exp_w_q.delete(); forced_q.delete();
    b_owed = 0;
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("post_reset_idle", {s_awready, dbg_state, m_awvalid, m_wvalid}, {1'b1, ST_IDLE, 2'b00});

    run_txn(32'h7000, 8'd17, 3'd1, BURST_INCR, 4'd6, -1);
    check("t8_aw", {obs_addr_q[1], obs_len_q[1]}, {32'h7020, 4'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

endmodule
